// File: rtl/uart_rx_if.sv
// Handshake bundle between the 16x-oversampled UART receiver and the core logic.
// The master side supplies the baud enable and serial line; the slave is the receiver.
interface uart_rx_if #(
  parameter int DATA_BIT = 8
);
  logic                sample_tick;
  logic                RxD;
  logic [DATA_BIT-1:0] data_out;
  logic                rx_done;
  logic                parity_err;
  logic                frame_err;
  logic                busy;

  modport master (
    output sample_tick, RxD,
    input  data_out, rx_done, parity_err, frame_err, busy
  );

  modport slave (
    input  sample_tick, RxD,
    output data_out, rx_done, parity_err, frame_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, start-bit glitch rejection, optional even parity,
// 1 or 2 stop bits. Received word is held until the next rx_done strobe.
module uart_rx #(
  parameter int DATA_BIT       = 8,
  parameter int PARITY_ENABLED = 1,
  parameter int STOP_BIT       = 1
) (
  input  logic      clk,
  input  logic      reset,
  uart_rx_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [3:0] LAST_DATA = 4'(DATA_BIT - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BIT - 1);
  localparam logic [3:0] MID_TICK  = 4'd7;
  localparam logic [3:0] END_TICK  = 4'd15;

  state_t              r_state;
  logic                r_rx_meta;
  logic                r_rx_s;
  logic [3:0]          r_tick_cnt;
  logic [3:0]          r_bit_cnt;
  logic [DATA_BIT-1:0] r_shift;
  logic                r_perr;
  logic                r_ferr;
  logic [DATA_BIT-1:0] r_data_out;
  logic                r_rx_done;
  logic                r_parity_err;
  logic                r_frame_err;
  logic                r_busy;

  wire w_tick = bus.sample_tick;

  // Synchronizer resets to the idle line level so reset cannot fake a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= bus.RxD;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_tick_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_perr       <= 1'b0;
      r_ferr       <= 1'b0;
      r_data_out   <= '0;
      r_rx_done    <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_rx_done <= 1'b0;
      if (w_tick) begin
        case (r_state)
          IDLE: begin
            r_tick_cnt <= '0;
            if (!r_rx_s) begin
              r_state <= START;
              r_busy  <= 1'b1;
              r_perr  <= 1'b0;
              r_ferr  <= 1'b0;
            end
          end

          START: begin
            if (r_tick_cnt == MID_TICK) begin
              r_tick_cnt <= '0;
              r_bit_cnt  <= '0;
              if (!r_rx_s) begin
                r_state <= DATA;
              end else begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end

          DATA: begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
            if (r_tick_cnt == END_TICK) begin
              // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
              r_shift <= {r_rx_s, r_shift[DATA_BIT-1:1]};
              if (r_bit_cnt == LAST_DATA) begin
                r_bit_cnt <= '0;
                r_state   <= (PARITY_ENABLED != 0) ? PARITY : STOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end

          PARITY: begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
            if (r_tick_cnt == END_TICK) begin
              r_perr    <= ^{r_shift, r_rx_s};
              r_bit_cnt <= '0;
              r_state   <= STOP;
            end
          end

          STOP: begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
            if (r_tick_cnt == END_TICK) begin
              r_ferr <= r_ferr | ~r_rx_s;
              if (r_bit_cnt == LAST_STOP) begin
                r_data_out   <= r_shift;
                r_parity_err <= r_perr;
                r_frame_err  <= r_ferr | ~r_rx_s;
                r_rx_done    <= 1'b1;
                r_busy       <= 1'b0;
                r_bit_cnt    <= '0;
                r_state      <= IDLE;
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end

          default: begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_busy     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.rx_done    = r_rx_done;
  assign bus.parity_err = r_parity_err;
  assign bus.frame_err  = r_frame_err;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx: default-config DUT plus a 7N2 variant.
// Stimulus pushes expected frames; a negedge monitor pops on every rx_done.
module tb_uart_rx;

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic r_tick = 1'b0;
  logic [1:0] r_tcnt = 2'd0;
  logic r_line0 = 1'b1;
  logic r_line1 = 1'b1;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];
  longint t_prev = 0;
  longint t_last = 0;
  logic pb0 = 1'b0;
  logic pb1 = 1'b0;

  uart_rx_if #(.DATA_BIT(8)) b0();
  uart_rx_if #(.DATA_BIT(7)) b1();

  assign b0.sample_tick = r_tick;
  assign b0.RxD         = r_line0;
  assign b1.sample_tick = r_tick;
  assign b1.RxD         = r_line1;

  uart_rx #(.DATA_BIT(8), .PARITY_ENABLED(1), .STOP_BIT(1)) dut0 (
    .clk(clk), .reset(reset), .bus(b0)
  );

  uart_rx #(.DATA_BIT(7), .PARITY_ENABLED(0), .STOP_BIT(2)) dut1 (
    .clk(clk), .reset(reset), .bus(b1)
  );

  always #5 clk = ~clk;

  // One tick every 4 clk, so one bit time is 64 clk.
  always @(negedge clk) begin
    r_tcnt <= r_tcnt + 2'd1;
    r_tick <= (r_tcnt == 2'd3);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (b0.rx_done) begin
      t_prev = t_last;
      t_last = $time;
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0 unexpected rx_done: data %0h", b0.data_out);
      end else begin
        e = q0.pop_front();
        chk("dut0 data_out", 32'(b0.data_out), 32'(e.d[7:0]));
        chk("dut0 parity_err", 32'(b0.parity_err), 32'(e.pe));
        chk("dut0 frame_err", 32'(b0.frame_err), 32'(e.fe));
        chk("dut0 busy at done", 32'(b0.busy), 32'd0);
        chk("dut0 busy before done", 32'(pb0), 32'd1);
      end
    end
    if (b1.rx_done) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1 unexpected rx_done: data %0h", b1.data_out);
      end else begin
        e = q1.pop_front();
        chk("dut1 data_out", 32'(b1.data_out), 32'(e.d[6:0]));
        chk("dut1 parity_err", 32'(b1.parity_err), 32'(e.pe));
        chk("dut1 frame_err", 32'(b1.frame_err), 32'(e.fe));
      end
    end
    pb0 = b0.busy;
    pb1 = b1.busy;
  end

  function automatic logic [15:0] fr8(input logic [7:0] d, input logic par, input logic stp);
    return {5'b0, stp, par, d, 1'b0};
  endfunction

  task automatic send(input int sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) r_line0 = bits[i];
      else          r_line1 = bits[i];
      repeat (64) @(negedge clk);
    end
    if (sel == 0) r_line0 = 1'b1;
    else          r_line1 = 1'b1;
  endtask

  task automatic idle(input int nbits);
    repeat (64 * nbits) @(negedge clk);
  endtask

  task automatic push0(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d = {1'b0, d}; e.pe = pe; e.fe = fe;
    q0.push_back(e);
  endtask

  initial begin
    exp_t e1;
    repeat (8) @(negedge clk);
    chk("rst data_out", 32'(b0.data_out), 32'h0);
    chk("rst rx_done", 32'(b0.rx_done), 32'h0);
    chk("rst flags", 32'({b0.parity_err, b0.frame_err}), 32'h0);
    chk("rst busy", 32'(b0.busy), 32'h0);
    chk("rst dut1 outputs", 32'({b1.data_out, b1.busy, b1.rx_done}), 32'h0);
    reset = 1'b0;
    idle(2);

    // clean frame
    push0(8'hA5, 1'b0, 1'b0);
    send(0, fr8(8'hA5, 1'b0, 1'b1), 11);
    idle(2);

    // glitch: 4 ticks low then high
    r_line0 = 1'b0;
    repeat (16) @(negedge clk);
    chk("glitch busy in start", 32'(b0.busy), 32'd1);
    r_line0 = 1'b1;
    idle(2);
    chk("glitch busy back", 32'(b0.busy), 32'd0);
    chk("glitch data_out held", 32'(b0.data_out), 32'hA5);

    // parity error
    push0(8'h3C, 1'b1, 1'b0);
    send(0, fr8(8'h3C, 1'b1, 1'b1), 11);
    idle(2);

    // frame error then clean frame
    push0(8'h55, 1'b0, 1'b1);
    send(0, fr8(8'h55, 1'b0, 1'b0), 11);
    idle(3);
    push0(8'h0F, 1'b0, 1'b0);
    send(0, fr8(8'h0F, 1'b0, 1'b1), 11);
    idle(2);

    // back-to-back
    push0(8'h00, 1'b0, 1'b0);
    push0(8'hFF, 1'b0, 1'b0);
    send(0, fr8(8'h00, 1'b0, 1'b1), 11);
    send(0, fr8(8'hFF, 1'b0, 1'b1), 11);
    idle(2);
    chk("b2b spacing", 32'(t_last - t_prev), 32'd7040);
    chk("b2b last data", 32'(b0.data_out), 32'hFF);

    // reset during data bit 3 of 0x81; transmitter abandons the frame too
    send(0, 16'b0000_0000_0000_0010, 4);
    r_line0 = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    r_line0 = 1'b1;
    chk("midrst data_out", 32'(b0.data_out), 32'h0);
    chk("midrst flags", 32'({b0.parity_err, b0.frame_err, b0.rx_done}), 32'h0);
    chk("midrst busy", 32'(b0.busy), 32'h0);
    idle(3);
    chk("midrst still idle", 32'(b0.busy), 32'h0);
    push0(8'h42, 1'b0, 1'b0);
    send(0, fr8(8'h42, 1'b0, 1'b1), 11);
    idle(2);

    // 7 data bits, no parity, 2 stop bits
    e1.d = 9'h06B; e1.pe = 1'b0; e1.fe = 1'b0;
    q1.push_back(e1);
    send(1, {6'b0, 2'b11, 7'h6B, 1'b0}, 10);
    idle(2);

    chk("dut0 frames outstanding", 32'(q0.size()), 32'd0);
    chk("dut1 frames outstanding", 32'(q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver paired with the team's 16x-oversampled transmitter.
- Recovers serial frames from the RxD line and presents the received word to the core logic with a one-cycle strobe.
- Frame format: start bit (0), DATA_BIT data bits LSB first, optional even parity bit, STOP_BIT stop bits (1).
- Timing comes from the shared 16x-baud sample_tick, used here as a single-clk clock enable.

Parameters:
- DATA_BIT, 8: data bits per frame. Legal range 5..9.
- PARITY_ENABLED, 1: 1 = one even-parity bit follows the data; 0 = no parity bit.
- STOP_BIT, 1: number of stop bits. Legal values 1 or 2.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- sample_tick  input  1  16x-baud enable; high for exactly one clk cycle per tick.
- RxD  input  1  asynchronous serial input; idles high.
- data_out  output  DATA_BIT  last received word; holds its value until the next rx_done.
- rx_done  output  1  one-clk pulse when a complete frame has been received.
- parity_err  output  1  even-parity mismatch for the frame flagged by rx_done; 0 when PARITY_ENABLED=0.
- frame_err  output  1  at least one stop-bit sample was 0, for the frame flagged by rx_done.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset:
  - Sets state IDLE; tick_cnt=0, bit_cnt=0, shift register=0.
  - data_out=0, rx_done=0, parity_err=0, frame_err=0, busy=0.
  - Synchronizer flops are set to 1.
  - Reset at any point, including mid-frame, abandons the frame with no rx_done.
- Input sync: RxD passes through a 2-flop synchronizer (rx_s) on clk. All decisions below use rx_s.
- Counters:
  - tick_cnt is 4 bits and advances only on clk cycles where sample_tick=1.
  - Every state change clears tick_cnt to 0.
- IDLE:
  - rx_s=0 on a sample_tick cycle -> START.
  - Otherwise remain in IDLE.
- START:
  - On the tick where tick_cnt==7 (mid start bit), re-check rx_s.
  - rx_s=0 -> DATA, with bit_cnt=0.
  - rx_s=1 -> IDLE. Glitch rejected; no flags, no rx_done.
- DATA:
  - On the tick where tick_cnt==15, sample rx_s.
  - Shift right with the sample entering the MSB, so after DATA_BIT samples the first-received bit sits at bit 0. Then bit_cnt++.
  - When bit_cnt reaches DATA_BIT-1 at a sample -> PARITY if PARITY_ENABLED=1, else STOP.
- PARITY:
  - On the tick where tick_cnt==15, sample rx_s.
  - perr_int = XOR(data bits, sample). Even parity: error when the XOR result is 1.
  - -> STOP with bit_cnt=0.
- STOP:
  - On each tick where tick_cnt==15, sample rx_s; a 0 sets ferr_int.
  - After STOP_BIT samples, on that same clk edge:
    - data_out <= shift register;
    - parity_err <= perr_int;
    - frame_err <= ferr_int;
    - rx_done <= 1 for one clk;
    - -> IDLE.
  - A new falling edge can be detected on the next tick, so back-to-back frames need no extra idle time.
- Error handling:
  - A frame with frame_err=1 or parity_err=1 is still delivered; data_out is updated.
  - Internal error flags clear on entry to START.
- rx_done is high only in the single clk cycle after the final stop sample; zero otherwise.
- sample_tick=0 freezes all counters and state except the synchronizer.
- Latency: rx_done rises 2 clk (synchronizer) plus at most 1 tick after the centre of the last stop bit.

Test Plan:
- Bench setup for all cases: sample_tick every 4 clk, so one bit = 64 clk. Default parameters unless noted.
- Clean frame: send 0xA5 with parity 0 and stop 1 -> single rx_done pulse; data_out=0xA5, parity_err=0, frame_err=0; busy falls with rx_done.
- Glitch: drive RxD low for 4 ticks then high -> state returns to IDLE, rx_done never asserts, data_out unchanged.
- Parity error: send 0x3C with parity bit 1 -> rx_done; data_out=0x3C, parity_err=1, frame_err=0.
- Frame error: send 0x55 with a correct parity bit and stop bit 0, then line high -> data_out=0x55, frame_err=1. A following 0x0F frame is received cleanly with both flags 0.
- Back-to-back: send 0x00 then 0xFF with no idle gap -> two rx_done pulses 11 bit-times apart, data_out=0x00 then 0xFF.
- Reset mid-frame: assert reset for 1 clk during data bit 3 of 0x81 -> no rx_done, all outputs 0. The next 0x42 frame is received correctly.
- Config variant (PARITY_ENABLED=0, STOP_BIT=2, DATA_BIT=7): send 0x6B -> data_out=0x6B, parity_err=0.
